// File: rtl/line_follow_seq.sv
// Run sequencer for the line-follower drive path: decodes UART go/stop commands
// and gates the PID enable and error strobe on line presence, obstacles and loss timeouts.
module line_follow_seq #(
    parameter int FAST_SIM   = 0,
    parameter int SETTLE_VLD = 3,
    parameter int LOST_TMO   = 5000000,
    parameter int BUZZ_DIV   = 12500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_rdy,
    input  logic [7:0] cmd,
    output logic       clr_cmd_rdy,
    input  logic       err_raw_vld,
    input  logic       line_present,
    input  logic       obstacle,
    input  logic       moving,
    output logic       go,
    output logic       err_vld,
    output logic       buzz_en,
    output logic [2:0] state
);

    localparam int TMO  = (FAST_SIM != 0) ? (LOST_TMO >> 8) : LOST_TMO;
    localparam int BDIV = (FAST_SIM != 0) ? (BUZZ_DIV >> 8) : BUZZ_DIV;
    localparam int SW   = $clog2(SETTLE_VLD + 1);

    localparam logic [22:0]   LOST_LAST  = 23'(TMO - 1);
    localparam logic [13:0]   BUZZ_LAST  = 14'(BDIV - 1);
    localparam logic [SW-1:0] SETTLE_TGT = SW'(SETTLE_VLD);
    localparam logic [7:0]    CMD_GO     = 8'h47;
    localparam logic [7:0]    CMD_STOP   = 8'h53;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        RUN    = 3'd2,
        LOST   = 3'd3,
        HALT   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [22:0]   lost_q, lost_d;
    logic [13:0]   buzz_cnt_q, buzz_cnt_d;
    logic          buzz_q, buzz_d;
    logic          go_q, go_d;
    logic          clr_q, clr_d;
    logic          accept, cmd_go, cmd_stop;
    logic          moving_unused;

    function automatic logic [SW-1:0] settle_inc(input logic [SW-1:0] v);
        return (v >= SETTLE_TGT) ? SETTLE_TGT : v + SW'(1);
    endfunction

    function automatic logic [22:0] lost_inc(input logic [22:0] v);
        return (v == '1) ? v : v + 23'd1;
    endfunction

    function automatic logic [13:0] buzz_inc(input logic [13:0] v);
        return (v == '1) ? v : v + 14'd1;
    endfunction

    // The loss timeout deliberately ignores whether the robot is still moving.
    assign moving_unused = moving;

    // A byte is taken only when the previous one is not being cleared this cycle.
    assign accept   = cmd_rdy & ~clr_q;
    assign cmd_go   = accept && (cmd == CMD_GO);
    assign cmd_stop = accept && (cmd == CMD_STOP);
    assign clr_d    = accept;

    always_comb begin
        err_vld = 1'b0;
        case (state_q)
            SETTLE:  err_vld = err_raw_vld;
            RUN:     err_vld = err_raw_vld & line_present;
            default: err_vld = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        lost_d     = lost_q;
        buzz_cnt_d = buzz_cnt_q;
        buzz_d     = buzz_q;
        if (cmd_stop) begin
            state_d    = IDLE;
            settle_d   = '0;
            lost_d     = '0;
            buzz_cnt_d = '0;
            buzz_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_go) begin
                        state_d  = SETTLE;
                        settle_d = '0;
                    end
                end
                SETTLE: begin
                    if (err_raw_vld)
                        settle_d = line_present ? settle_inc(settle_q) : '0;
                    // An obstacle parks us here with the count held at its target.
                    if (settle_d == SETTLE_TGT && !obstacle)
                        state_d = RUN;
                end
                RUN: begin
                    if (obstacle) begin
                        state_d    = HALT;
                        buzz_cnt_d = '0;
                        buzz_d     = 1'b1;
                    end else if (!line_present) begin
                        state_d = LOST;
                        lost_d  = '0;
                    end
                end
                LOST: begin
                    if (obstacle || (!line_present && lost_q == LOST_LAST)) begin
                        state_d    = HALT;
                        lost_d     = '0;
                        buzz_cnt_d = '0;
                        buzz_d     = 1'b1;
                    end else if (line_present) begin
                        state_d = RUN;
                        lost_d  = '0;
                    end else begin
                        lost_d = lost_inc(lost_q);
                    end
                end
                HALT: begin
                    if (cmd_go && !obstacle) begin
                        state_d    = SETTLE;
                        settle_d   = '0;
                        buzz_cnt_d = '0;
                        buzz_d     = 1'b0;
                    end else if (buzz_cnt_q == BUZZ_LAST) begin
                        buzz_cnt_d = '0;
                        buzz_d     = ~buzz_q;
                    end else begin
                        buzz_cnt_d = buzz_inc(buzz_cnt_q);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        go_d = (state_d == RUN) || (state_d == LOST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            settle_q   <= '0;
            lost_q     <= '0;
            buzz_cnt_q <= '0;
            buzz_q     <= 1'b0;
            go_q       <= 1'b0;
            clr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            lost_q     <= lost_d;
            buzz_cnt_q <= buzz_cnt_d;
            buzz_q     <= buzz_d;
            go_q       <= go_d;
            clr_q      <= clr_d;
        end
    end

    assign go          = go_q;
    assign clr_cmd_rdy = clr_q;
    assign buzz_en     = buzz_q;
    assign state       = state_q;

endmodule

// File: tb/tb_line_follow_seq.sv
// Bench for line_follow_seq: directed scenarios plus random traffic against a
// behavioural model of the run sequencer (FAST_SIM timing).
module tb_line_follow_seq;

    localparam int SETTLE_VLD = 3;
    localparam int TMO        = 5000000 / 256;
    localparam int BDIV       = 12500 / 256;
    localparam int M_IDLE = 0, M_SETTLE = 1, M_RUN = 2, M_LOST = 3, M_HALT = 4;
    localparam logic [7:0] C_G = 8'h47, C_S = 8'h53, C_X = 8'h58;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_rdy, err_raw_vld, line_present, obstacle, moving;
    logic [7:0] cmd;
    logic       clr_cmd_rdy, go, err_vld, buzz_en;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;
    int m_mode, m_good, m_lost_age, m_halt_age;
    bit m_clr;
    int hi, lo, n;
    logic seq_line [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    always #5 clk = ~clk;

    line_follow_seq #(
        .FAST_SIM(1), .SETTLE_VLD(SETTLE_VLD), .LOST_TMO(5000000), .BUZZ_DIV(12500)
    ) dut (
        .clk(clk), .rst(rst), .cmd_rdy(cmd_rdy), .cmd(cmd), .clr_cmd_rdy(clr_cmd_rdy),
        .err_raw_vld(err_raw_vld), .line_present(line_present), .obstacle(obstacle),
        .moving(moving), .go(go), .err_vld(err_vld), .buzz_en(buzz_en), .state(state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_good = 0; m_lost_age = 0; m_halt_age = 0; m_clr = 0;
    endtask

    function automatic bit exp_err();
        if (m_mode == M_SETTLE) return err_raw_vld;
        if (m_mode == M_RUN)    return err_raw_vld && line_present;
        return 1'b0;
    endfunction

    function automatic bit exp_buzz();
        return (m_mode == M_HALT) && (((m_halt_age / BDIV) % 2) == 0);
    endfunction

    // Reference behaviour for one clock, from the command/sensor rules.
    task automatic model_step();
        bit take;
        take  = cmd_rdy && !m_clr;
        m_clr = take;
        if (take && cmd == C_S) begin
            m_mode = M_IDLE; m_good = 0;
        end else if (m_mode == M_IDLE) begin
            if (take && cmd == C_G) begin m_mode = M_SETTLE; m_good = 0; end
        end else if (m_mode == M_SETTLE) begin
            if (err_raw_vld)
                m_good = line_present ? ((m_good < SETTLE_VLD) ? m_good + 1 : SETTLE_VLD) : 0;
            if (m_good == SETTLE_VLD && !obstacle) m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (obstacle) begin m_mode = M_HALT; m_halt_age = 0; end
            else if (!line_present) begin m_mode = M_LOST; m_lost_age = 0; end
        end else if (m_mode == M_LOST) begin
            if (obstacle) begin m_mode = M_HALT; m_halt_age = 0; end
            else if (line_present) m_mode = M_RUN;
            else begin
                m_lost_age++;
                if (m_lost_age >= TMO) begin m_mode = M_HALT; m_halt_age = 0; end
            end
        end else begin
            if (take && cmd == C_G && !obstacle) begin m_mode = M_SETTLE; m_good = 0; end
            else m_halt_age++;
        end
    endtask

    task automatic tick(input bit full);
        @(negedge clk);
        if (full) chk("err_vld", 32'(err_vld), 32'(exp_err()));
        @(posedge clk);
        model_step();
        #1;
        if (full) begin
            chk("state", 32'(state), 32'(m_mode));
            chk("go", 32'(go), 32'((m_mode == M_RUN) || (m_mode == M_LOST)));
            chk("buzz_en", 32'(buzz_en), 32'(exp_buzz()));
            chk("clr_cmd_rdy", 32'(clr_cmd_rdy), 32'(m_clr));
        end
    endtask

    // Receiver keeps cmd_rdy up until it sees the clear pulse.
    task automatic send_cmd(input logic [7:0] c);
        cmd_rdy = 1'b1; cmd = c;
        tick(1);
        chk("clr_pulse", 32'(clr_cmd_rdy), 32'd1);
        tick(1);
        chk("clr_once", 32'(clr_cmd_rdy), 32'd0);
        cmd_rdy = 1'b0;
    endtask

    task automatic strobe(input logic l, input logic [2:0] st_exp, input logic go_exp, input string tag);
        err_raw_vld = 1'b1; line_present = l;
        tick(1);
        chk({tag, "_state"}, 32'(state), 32'(st_exp));
        chk({tag, "_go"}, 32'(go), 32'(go_exp));
        err_raw_vld = 1'b0; line_present = 1'b1;
        tick(1);
    endtask

    initial begin
        rst = 1'b1; cmd_rdy = 1'b0; cmd = 8'h00; err_raw_vld = 1'b0;
        line_present = 1'b1; obstacle = 1'b0; moving = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_go", 32'(go), 32'd0);
        chk("rst_buzz", 32'(buzz_en), 32'd0);
        chk("rst_clr", 32'(clr_cmd_rdy), 32'd0);
        rst = 1'b0;
        tick(1);

        // Go, then three good strobes: go rises right after the third.
        send_cmd(C_G);
        chk("g_settle", 32'(state), 32'(M_SETTLE));
        strobe(1'b1, 3'd1, 1'b0, "s1");
        strobe(1'b1, 3'd1, 1'b0, "s2");
        strobe(1'b1, 3'd2, 1'b1, "s3");

        // Short line loss: coast in LOST, recover to RUN.
        moving = 1'b1;
        line_present = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            err_raw_vld = i[0];
            tick(1);
        end
        chk("short_lost", 32'(state), 32'(M_LOST));
        err_raw_vld = 1'b0; line_present = 1'b1;
        tick(1);
        chk("recover_run", 32'(state), 32'(M_RUN));
        chk("recover_go", 32'(go), 32'd1);

        // Long line loss: timeout into HALT, then the buzzer square wave.
        line_present = 1'b0; moving = 1'b0;
        n = 0;
        while (state !== 3'(M_HALT) && n < TMO + 100) begin
            n++;
            tick((n % 128) == 0);
        end
        chk("halt_reached", 32'(state), 32'(M_HALT));
        chk("lost_cycles", 32'(n), 32'(TMO + 1));
        chk("halt_go", 32'(go), 32'd0);
        hi = 0;
        while (buzz_en === 1'b1 && hi < 200) begin hi++; tick(1); end
        lo = 0;
        while (buzz_en === 1'b0 && lo < 200) begin lo++; tick(1); end
        chk("buzz_hi", 32'(hi), 32'(BDIV));
        chk("buzz_lo", 32'(lo), 32'(BDIV));

        // Restart from HALT, then stop and obstacle in the same cycle.
        line_present = 1'b1;
        send_cmd(C_G);
        chk("halt_to_settle", 32'(state), 32'(M_SETTLE));
        chk("halt_exit_buzz", 32'(buzz_en), 32'd0);
        strobe(1'b1, 3'd1, 1'b0, "r1");
        strobe(1'b1, 3'd1, 1'b0, "r2");
        strobe(1'b1, 3'd2, 1'b1, "r3");
        obstacle = 1'b1; cmd_rdy = 1'b1; cmd = C_S;
        tick(1);
        chk("stop_beats_obst", 32'(state), 32'(M_IDLE));
        chk("stop_go", 32'(go), 32'd0);
        cmd_rdy = 1'b0; obstacle = 1'b0;
        tick(1);
        send_cmd(C_X);
        chk("unknown_ignored", 32'(state), 32'(M_IDLE));

        // Settle with a bad strobe in the middle restarts the count.
        send_cmd(C_G);
        for (int k = 0; k < 6; k++)
            strobe(seq_line[k], (k == 5) ? 3'd2 : 3'd1, (k == 5) ? 1'b1 : 1'b0, "toggle");

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            cmd_rdy = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: cmd = C_G;
                5, 6:          cmd = C_S;
                default:       cmd = 8'($urandom);
            endcase
            err_raw_vld = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 29) == 0) line_present = ~line_present;
            if ($urandom_range(0, 99) == 0) obstacle = ~obstacle;
            moving = 1'($urandom);
            tick(1);
        end

        // Asynchronous reset in the middle of a run.
        cmd_rdy = 1'b0; err_raw_vld = 1'b0; line_present = 1'b1; obstacle = 1'b0;
        tick(1);
        tick(1);
        send_cmd(C_S);
        send_cmd(C_G);
        strobe(1'b1, 3'd1, 1'b0, "m1");
        strobe(1'b1, 3'd1, 1'b0, "m2");
        strobe(1'b1, 3'd2, 1'b1, "m3");
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_go", 32'(go), 32'd0);
        chk("async_state", 32'(state), 32'd0);
        chk("async_buzz", 32'(buzz_en), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("hold_state", 32'(state), 32'd0);
            chk("hold_go", 32'(go), 32'd0);
        end
        rst = 1'b0;
        model_reset();
        tick(1);
        tick(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
